bubble_sort_controller: RTL and testbench
=========================================

Name: bubble_sort_controller

Overview:
Sequencer for the bubble-sort datapath: a bank of N_REGS value registers, A/B compare registers, an i/j index mux, an A/B write-back mux and a load decoder. On start it walks bubble-sort passes, loads reg[i] into A and reg[j] into B, compares them, and swaps them through the write-back path when A > B. It drives only datapath control/index signals and reports busy/done/swap statistics to the top level.

Parameters:
N_REGS, 4, number of value registers sorted; legal 2..2**IDX_W
IDX_W, 2, width of register index (i, j)
DATA_W, 4, width of each value (A/B compare inputs)
CNT_W, 8, width of swap counter

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  level; sampled only in IDLE; begins a sort
a_val  input  DATA_W  current A compare register contents
b_val  input  DATA_W  current B compare register contents
idx_i  output  IDX_W  index i (lower element of pair)
idx_j  output  IDX_W  index j = idx_i+1
c_select  output  1  0 = datapath addresses reg[idx_i], 1 = reg[idx_j]
a_enable  output  1  load A from addressed register
b_enable  output  1  load B from addressed register
ab_select  output  1  write-back source: 0 = A, 1 = B
reg_load  output  1  enable decoder; writes write-back data into addressed register
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse on completion
swap_count  output  CNT_W  swaps performed in the current/last sort, saturating

Behaviour:
- Reset (async, rst_n low): state IDLE; idx_i=0, idx_j=1, pass=0, swapped flag=0, swap_count=0; all enables, c_select, ab_select, busy, done = 0. Reset mid-sort aborts immediately; no partial write completes.
- Outputs are Moore-decoded from registered state/counters; exactly one of a_enable/b_enable/reg_load high per cycle at most.
- States:
  IDLE: outputs idle. start=1 -> LOAD_A; idx_i=0, pass=0, swap_count cleared, swapped flag cleared.
  LOAD_A: c_select=0, a_enable=1 -> LOAD_B.
  LOAD_B: c_select=1, b_enable=1 -> COMPARE.
  COMPARE: no enables. Unsigned a_val > b_val -> WRITE_I; else (incl. equal, no swap) -> NEXT.
  WRITE_I: c_select=0, ab_select=1, reg_load=1 (reg[i] <= B) -> WRITE_J.
  WRITE_J: c_select=1, ab_select=0, reg_load=1 (reg[j] <= A); swap_count+1 (saturate at all-ones); swapped flag=1 -> NEXT.
  NEXT: if idx_i == N_REGS-2-pass: end of pass: if pass == N_REGS-2 -> DONE, else pass+1, idx_i=0, swapped flag cleared -> LOAD_A. Otherwise idx_i+1 -> LOAD_A.
  DONE: done=1 for this single cycle, busy=1 -> IDLE.
- Per comparison: 4 cycles without swap, 6 with swap. Total comparisons N_REGS*(N_REGS-1)/2.
- Latency: start sampled at edge t0; done high in cycle 1 + sum of comparison cycles after t0 (N_REGS=4, no swaps: cycle 25).
- start while busy ignored; start held high through DONE re-triggers from IDLE on next edge (back-to-back sorts allowed).
- N_REGS=2: single pass of one comparison, then DONE.
- idx_j always idx_i+1; never exceeds N_REGS-1.

Optional Feature:
BUBBLE_EARLY_EXIT_EN: when defined, at end of a pass with swapped flag=0, NEXT goes directly to DONE regardless of pass. Without it, all N_REGS-1 passes always run. swap_count and final register contents identical either way.

Test Plan:
- Reset mid-sort: assert rst_n low during WRITE_I -> all outputs 0 asynchronously, state IDLE, busy=0 next cycle, no further reg_load.
- Sorted input {0,1,2,3}, start pulse -> 6 comparisons, zero reg_load, swap_count=0, done in cycle 25 (cycle 13 with BUBBLE_EARLY_EXIT_EN).
- Reverse input {3,2,1,0} -> 6 swaps, registers end {0,1,2,3}, swap_count=6, done in cycle 37 both builds.
- Duplicates {2,2,1,1} -> equal pairs not swapped, result {1,1,2,2}, swap_count=4.
- start held high continuously from reset release -> second sort begins the cycle after DONE; start pulses while busy have no effect on idx_i/state sequence.
- Enable-exclusivity assertion over all scenarios: never more than one of a_enable/b_enable/reg_load high; idx_j == idx_i+1 always.

Source files
------------

// File: rtl/bubble_sort_controller.sv
// bubble_sort_controller: sequencer for the bubble-sort datapath.
// It walks bubble-sort passes over N_REGS registers and drives the index,
// load and write-back controls. It also reports busy/done and a swap count.
// Optional build macro: BUBBLE_EARLY_EXIT_EN. When it is defined, the sort
// finishes after the first pass that performs no swap.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for start; all controls low
// S_LOAD_A  | address reg[idx_i], load A
// S_LOAD_B  | address reg[idx_j], load B
// S_COMPARE | A/B settled; choose swap (A > B) or skip
// S_WRITE_I | reg[idx_i] <= B
// S_WRITE_J | reg[idx_j] <= A; count the swap
// S_NEXT    | advance to the next pair, the next pass, or finish
// S_DONE    | one-cycle completion pulse
module bubble_sort_controller #(
  parameter int N_REGS = 4,
  parameter int IDX_W  = 2,
  parameter int DATA_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a_val,
  input  logic [DATA_W-1:0] b_val,
  output logic [IDX_W-1:0]  idx_i,
  output logic [IDX_W-1:0]  idx_j,
  output logic              c_select,
  output logic              a_enable,
  output logic              b_enable,
  output logic              ab_select,
  output logic              reg_load,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  swap_count
);

`ifdef BUBBLE_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  // The last pair index of pass 0 is also the number of the final pass.
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REGS - 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_A,
    S_LOAD_B,
    S_COMPARE,
    S_WRITE_I,
    S_WRITE_J,
    S_NEXT,
    S_DONE
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] pass;
  logic             swapped;

  // Sequencer: state, pair index, pass number, swap flag and swap counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      idx_i      <= '0;
      pass       <= '0;
      swapped    <= 1'b0;
      swap_count <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state      <= S_LOAD_A;
            idx_i      <= '0;
            pass       <= '0;
            swapped    <= 1'b0;
            swap_count <= '0;
          end
        end
        S_LOAD_A:  state <= S_LOAD_B;
        S_LOAD_B:  state <= S_COMPARE;
        S_COMPARE: state <= (a_val > b_val) ? S_WRITE_I : S_NEXT;
        S_WRITE_I: state <= S_WRITE_J;
        S_WRITE_J: begin
          if (swap_count != '1) swap_count <= swap_count + 1'b1;
          swapped <= 1'b1;
          state   <= S_NEXT;
        end
        S_NEXT: begin
          if (idx_i == LAST_IDX - pass) begin
            // A pass with no swap means the array is already ordered.
            if (pass == LAST_IDX || (EARLY_EXIT && !swapped)) begin
              state <= S_DONE;
            end else begin
              pass    <= pass + 1'b1;
              idx_i   <= '0;
              swapped <= 1'b0;
              state   <= S_LOAD_A;
            end
          end else begin
            idx_i <= idx_i + 1'b1;
            state <= S_LOAD_A;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore decode of datapath controls from the registered state.
  assign idx_j     = idx_i + 1'b1;
  assign c_select  = (state == S_LOAD_B) || (state == S_WRITE_J);
  assign a_enable  = (state == S_LOAD_A);
  assign b_enable  = (state == S_LOAD_B);
  assign ab_select = (state == S_WRITE_I);
  assign reg_load  = (state == S_WRITE_I) || (state == S_WRITE_J);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

endmodule

// File: tb/tb_bubble_sort_controller.sv
// Bench for bubble_sort_controller: behavioural register-bank datapath,
// table of sort vectors with hand-computed results, plus reset and
// back-to-back sequences.
module tb_bubble_sort_controller;

`ifdef BUBBLE_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] a_val, b_val;
  logic [1:0] idx_i, idx_j;
  logic       c_select, a_enable, b_enable, ab_select, reg_load, busy, done;
  logic [7:0] swap_count;

  bubble_sort_controller #(.N_REGS(4), .IDX_W(2), .DATA_W(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a_val(a_val), .b_val(b_val),
    .idx_i(idx_i), .idx_j(idx_j), .c_select(c_select), .a_enable(a_enable),
    .b_enable(b_enable), .ab_select(ab_select), .reg_load(reg_load),
    .busy(busy), .done(done), .swap_count(swap_count)
  );

  always #5 clk = ~clk;

  // Datapath model: register bank, A/B registers, index mux and write-back.
  logic [3:0][3:0] mem;
  logic [3:0]      a_q, b_q;
  logic [15:0]     init_v;
  logic            do_init;
  logic [1:0]      addr;
  assign addr  = c_select ? idx_j : idx_i;
  assign a_val = a_q;
  assign b_val = b_q;

  always @(posedge clk) begin
    if (do_init) mem <= init_v;
    else if (reg_load) mem[addr] <= ab_select ? b_q : a_q;
    if (a_enable) a_q <= mem[addr];
    if (b_enable) b_q <= mem[addr];
  end

  typedef struct {
    logic [15:0] init;
    logic [15:0] exp_regs;
    int          exp_swaps;
    int          exp_cyc;
    int          exp_cyc_ee;
    int          toggle;
  } vec_t;

  vec_t vecs[5];
  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [15:0] v);
    @(negedge clk);
    init_v  = v;
    do_init = 1'b1;
    @(negedge clk);
    do_init = 1'b0;
  endtask

  // Counts cycles after the start edge until done, bounded; also tracks
  // reg_load pulses and control-exclusivity / index violations.
  task automatic wait_done(input int toggle, output int n, output int loads, output int viol);
    bit got;
    got = 0; n = 0; loads = 0; viol = 0;
    while (n < 100 && !got) begin
      @(negedge clk);
      n++;
      if (reg_load) loads++;
      if ((32'(a_enable) + 32'(b_enable) + 32'(reg_load)) > 1) viol++;
      if (idx_j !== 2'(idx_i + 2'd1)) viol++;
      if (toggle != 0) start = (n < 10) ? n[0] : 1'b0;
      if (done === 1'b1) got = 1;
    end
    if (!got) n = -1;
  endtask

  initial begin
    int n, loads, viol, busy_seen;
    bit found;

    vecs[0] = '{16'h3210, 16'h3210, 0, 25, 13, 0};
    vecs[1] = '{16'h0123, 16'h3210, 6, 37, 37, 0};
    vecs[2] = '{16'h1122, 16'h2211, 4, 33, 33, 0};
    vecs[3] = '{16'h3201, 16'h3210, 1, 27, 23, 1};
    vecs[4] = '{16'h0213, 16'h3210, 5, 35, 35, 1};

    rst_n = 1'b0; start = 1'b0; do_init = 1'b0; init_v = '0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", {busy, done, a_enable, b_enable, reg_load, c_select, ab_select}, 7'b0);
    check("rst_idx_i", idx_i, 2'd0);
    check("rst_idx_j", idx_j, 2'd1);
    check("rst_swap_count", swap_count, 8'd0);
    rst_n = 1'b1;

    // Table-driven sorts.
    for (int k = 0; k < 5; k++) begin
      preload(vecs[k].init);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_done(vecs[k].toggle, n, loads, viol);
      check($sformatf("v%0d_done_cycle", k), n, EE ? vecs[k].exp_cyc_ee : vecs[k].exp_cyc);
      check($sformatf("v%0d_swap_count", k), swap_count, vecs[k].exp_swaps);
      check($sformatf("v%0d_reg_loads", k), loads, 2 * vecs[k].exp_swaps);
      check($sformatf("v%0d_excl", k), viol, 0);
      check($sformatf("v%0d_regs", k), mem, vecs[k].exp_regs);
      check($sformatf("v%0d_busy_at_done", k), busy, 1'b1);
      @(negedge clk);
      check($sformatf("v%0d_done_pulse", k), done, 1'b0);
      check($sformatf("v%0d_idle", k), busy, 1'b0);
    end

    // Reset during WRITE_I aborts the swap before it lands.
    preload(16'h0123);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      if (reg_load && ab_select) found = 1;
    end
    check("rst_mid_found_write_i", found, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mid_ctrl", {busy, done, a_enable, b_enable, reg_load, c_select, ab_select}, 7'b0);
    check("rst_mid_idx", {idx_i, idx_j}, 4'b0001);
    check("rst_mid_swap_count", swap_count, 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    busy_seen = 0; loads = 0;
    repeat (5) begin
      @(negedge clk);
      if (busy) busy_seen++;
      if (reg_load) loads++;
    end
    check("rst_mid_busy_after", busy_seen, 0);
    check("rst_mid_no_load", loads, 0);
    check("rst_mid_regs", mem, 16'h0123);

    // start held high from reset release: back-to-back sorts.
    rst_n = 1'b0;
    preload(16'h3210);
    start = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    wait_done(0, n, loads, viol);
    check("hold_first_done", n, EE ? 13 : 25);
    @(negedge clk);
    check("hold_idle_gap", {busy, done}, 2'b00);
    @(negedge clk);
    check("hold_restart", {busy, a_enable, idx_i}, 4'b1100);
    wait_done(0, n, loads, viol);
    check("hold_second_done", n, EE ? 12 : 24);
    check("hold_excl", viol, 0);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("hold_stopped", busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
